// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi decoder input/output interfaces.
// Symbols per word is computed by a helper so both interfaces agree.
package viterbi_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DEF_SIZE_IN  = 8;
    localparam int DEF_SIZE_OUT = 2;

    function automatic int syms_per_word(input int size_in, input int size_out);
        return size_in / size_out;
    endfunction
endpackage

// File: rtl/input_word_buffer.sv
// One-entry pending word register that lets the front end accept the next word
// while the current word is still being shifted out.
module input_word_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
            last  <= push_last;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/input_interface_block.sv
// Parallel-to-serial front end: splits SIZE_IN-bit words into SIZE_OUT-bit
// symbols, MSB first, with a pending buffer to avoid bubbles between words.
module input_interface_block
    import viterbi_pkg::*;
#(
    parameter int SIZE_IN  = DEF_SIZE_IN,
    parameter int SIZE_OUT = DEF_SIZE_OUT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [SIZE_IN-1:0]  i_data,
    input  logic                i_last,
    output logic                o_ready,
    output logic                o_valid,
    output logic [SIZE_OUT-1:0] o_data,
    output logic                o_last,
    input  logic                i_ready,
    output logic                o_busy
);
    localparam int N  = syms_per_word(SIZE_IN, SIZE_OUT);
    localparam int CW = $clog2(N + 1);

    state_t             state;
    logic [SIZE_IN-1:0] sreg;
    logic               slast;
    logic [CW-1:0]      count;

    logic [SIZE_IN-1:0] pend_data;
    logic               pend_last;
    logic               pend_valid;

    logic up_xfer, dn_xfer, word_done, bypass, pend_push, pend_pop;

    assign o_ready   = !pend_valid && !i_rst;
    assign o_valid   = (state == SHIFT);
    assign o_data    = sreg[SIZE_IN-1 -: SIZE_OUT];
    assign o_last    = o_valid && slast && (count == CW'(1));
    assign o_busy    = o_valid || pend_valid;

    assign up_xfer   = i_valid && o_ready;
    assign dn_xfer   = o_valid && i_ready;
    assign word_done = dn_xfer && (count == CW'(1));
    // A word arriving as the current one finishes skips the pending entry.
    assign bypass    = word_done && !pend_valid && up_xfer;
    assign pend_push = up_xfer && (state == SHIFT) && !bypass;
    assign pend_pop  = word_done && pend_valid;

    input_word_buffer #(.WIDTH(SIZE_IN)) u_buf (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (pend_push),
        .push_data(i_data),
        .push_last(i_last),
        .pop      (pend_pop),
        .data     (pend_data),
        .last     (pend_last),
        .valid    (pend_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            sreg  <= '0;
            slast <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_xfer) begin
                        sreg  <= i_data;
                        slast <= i_last;
                        count <= CW'(N);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dn_xfer) begin
                        if (count > CW'(1)) begin
                            sreg  <= sreg << SIZE_OUT;
                            count <= count - CW'(1);
                        end else if (pend_valid) begin
                            sreg  <= pend_data;
                            slast <= pend_last;
                            count <= CW'(N);
                        end else if (up_xfer) begin
                            sreg  <= i_data;
                            slast <= i_last;
                            count <= CW'(N);
                        end else begin
                            sreg  <= '0;
                            slast <= 1'b0;
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
